// File: rtl/matrix_result_serializer.sv
// Purpose: capture a 3x3 matrix result (c0..c8) and its cycle count when the
//          multiplier's done level rises, then send them as a 21-byte frame
//          (0xA5 header, c0..c8 MSB first, cycle_count MSB first) over a
//          valid/ready byte interface.
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   done         completion level from the multiplier
//   c0..c8       result matrix words, row-major
//   cycle_count  multiplier cycle count
//   tx_ready     downstream accepts the presented byte
//   tx_data      presented frame byte, 0x00 when idle
//   tx_valid     tx_data valid
//   busy         frame in flight
//   frame_done   one-cycle pulse after the last byte is accepted
//   overrun      sticky; a done rising edge arrived mid-frame and was dropped
module matrix_result_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] c0,
  input  logic [15:0] c1,
  input  logic [15:0] c2,
  input  logic [15:0] c3,
  input  logic [15:0] c4,
  input  logic [15:0] c5,
  input  logic [15:0] c6,
  input  logic [15:0] c7,
  input  logic [15:0] c8,
  input  logic [15:0] cycle_count,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned N_WORDS   = 9;
  localparam int unsigned FRAME_LEN = 21;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned SLOTS     = 32;
  localparam logic [BYTE_W-1:0] HEADER   = 8'hA5;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_d;
  logic                  rise;
  logic                  capture_en;
  logic                  frame_done_d;
  logic                  overrun_set;
  logic [WORD_W-1:0]     cap_q [N_WORDS];
  logic [WORD_W-1:0]     cap_cc_q;
  logic [WORD_W-1:0]     words_in [N_WORDS];
  logic [WORD_W-1:0]     src [N_WORDS];
  logic [WORD_W-1:0]     src_cc;
  logic [BYTE_W-1:0]     frame [SLOTS];
  logic [BYTE_W-1:0]     tx_data_d;

  assign words_in[0] = c0;
  assign words_in[1] = c1;
  assign words_in[2] = c2;
  assign words_in[3] = c3;
  assign words_in[4] = c4;
  assign words_in[5] = c5;
  assign words_in[6] = c6;
  assign words_in[7] = c7;
  assign words_in[8] = c8;

  assign rise = done & ~done_d;

  // Next-state / control
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    capture_en   = 1'b0;
    frame_done_d = 1'b0;
    overrun_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          capture_en = 1'b1;
          idx_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (rise) overrun_set = 1'b1;
        // tx_valid is always 1 in SEND, so tx_ready alone marks a transfer
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame image built from the values that will be held after this edge,
  // so the registered tx_data is already correct in the first SEND cycle.
  always_comb begin
    for (int k = 0; k < int'(N_WORDS); k++) begin
      src[k] = capture_en ? words_in[k] : cap_q[k];
    end
    src_cc = capture_en ? cycle_count : cap_cc_q;
    for (int i = 0; i < int'(SLOTS); i++) begin
      frame[i] = '0;
    end
    frame[0] = HEADER;
    for (int k = 0; k < int'(N_WORDS); k++) begin
      frame[1 + 2 * k] = src[k][WORD_W-1:BYTE_W];
      frame[2 + 2 * k] = src[k][BYTE_W-1:0];
    end
    frame[FRAME_LEN - 2] = src_cc[WORD_W-1:BYTE_W];
    frame[FRAME_LEN - 1] = src_cc[BYTE_W-1:0];
    tx_data_d = (state_d == SEND) ? frame[idx_d] : '0;
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      done_d     <= 1'b0;
      cap_cc_q   <= '0;
      for (int k = 0; k < int'(N_WORDS); k++) cap_q[k] <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_d     <= done;
      if (capture_en) begin
        cap_cc_q <= cycle_count;
        for (int k = 0; k < int'(N_WORDS); k++) cap_q[k] <= words_in[k];
      end
      tx_data    <= tx_data_d;
      tx_valid   <= (state_d == SEND);
      busy       <= (state_d == SEND);
      frame_done <= frame_done_d;
      if (overrun_set) overrun <= 1'b1;
    end
  end

endmodule
